// File: rtl/line_burst_responder.sv
// Line-wide memory responder: queues cache line read/write requests, services them against
// a 256-bit memory port and returns read lines as four 64-bit beats.
module line_burst_responder #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  bfp_addr,
    input  logic         bfp_read,
    input  logic         bfp_write,
    input  logic [63:0]  bfp_wdata,
    output logic         bfp_ready,
    output logic [31:0]  bfp_raddr,
    output logic [63:0]  bfp_rdata,
    output logic         bfp_rvalid,
    output logic [31:0]  lmem_addr,
    output logic         lmem_read,
    output logic         lmem_write,
    output logic [255:0] lmem_wdata,
    input  logic [255:0] lmem_rdata,
    input  logic         lmem_resp
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MEM_RD = 2'd1,
        S_MEM_WR = 2'd2,
        S_BURST  = 2'd3
    } state_t;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 2;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    state_t         r_state;
    state_t         w_state_nxt;

    // FIFO entry: {op (1 = write), line address [31:5]}
    logic [27:0]    r_fifo [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;

    logic           r_wcollect;
    logic           r_wbusy;
    logic [1:0]     r_wbeat;
    logic [26:0]    r_waddr;
    logic [255:0]   r_wbuf;

    logic [26:0]    r_cur_addr;
    logic [255:0]   r_linebuf;
    logic [1:0]     r_beat;

    logic           r_lmem_read;
    logic           r_lmem_write;
    logic           r_rvalid;
    logic [63:0]    r_rdata;
    logic [31:0]    r_raddr;

    logic           w_full;
    logic           w_empty;
    logic           w_rd_acc;
    logic           w_wr_acc;
    logic           w_wr_last;
    logic           w_push;
    logic           w_take;
    logic           w_pop;
    logic           w_bypass;
    logic           w_fifo_wr;
    logic [27:0]    w_push_ent;
    logic [27:0]    w_take_ent;
    logic [1:0]     w_beat_inc;
    logic           w_lmem_read_nxt;
    logic           w_lmem_write_nxt;
    logic           w_rvalid_nxt;
    logic [63:0]    w_rdata_nxt;
    logic [31:0]    w_raddr_nxt;
    logic           w_unused_addr_lsb;

    assign w_unused_addr_lsb = ^bfp_addr[4:0];

    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign bfp_ready  = !rst && !w_full && !r_wcollect && !r_wbusy;
    assign w_rd_acc   = bfp_read && bfp_ready;
    assign w_wr_acc   = bfp_write && !bfp_read && bfp_ready;
    assign w_wr_last  = r_wcollect && bfp_write && (r_wbeat == 2'd3);
    assign w_push     = w_rd_acc || w_wr_last;
    assign w_push_ent = w_rd_acc ? {1'b0, bfp_addr[31:5]} : {1'b1, r_waddr};

    // An idle FSM with an empty FIFO takes the incoming request directly so memory sees it next cycle.
    assign w_take     = (r_state == S_IDLE) && (!w_empty || w_push);
    assign w_pop      = (r_state == S_IDLE) && !w_empty;
    assign w_bypass   = w_take && w_empty;
    assign w_fifo_wr  = w_push && !w_bypass;
    assign w_take_ent = w_empty ? w_push_ent : r_fifo[r_rptr];
    assign w_beat_inc = r_beat + 2'd1;

    assign lmem_addr  = {r_cur_addr, 5'b0};
    assign lmem_wdata = r_wbuf;
    assign lmem_read  = r_lmem_read;
    assign lmem_write = r_lmem_write;
    assign bfp_rvalid = r_rvalid;
    assign bfp_rdata  = r_rdata;
    assign bfp_raddr  = r_raddr;

    always_ff @(posedge clk) begin
        if (w_fifo_wr) r_fifo[r_wptr] <= w_push_ent;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_fifo_wr) r_wptr <= r_wptr + AW'(1);
            if (w_pop)     r_rptr <= r_rptr + AW'(1);
            case ({w_fifo_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wcollect <= 1'b0;
            r_wbusy    <= 1'b0;
            r_wbeat    <= 2'd0;
            r_waddr    <= '0;
            r_wbuf     <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wbuf[63:0] <= bfp_wdata;
                r_waddr      <= bfp_addr[31:5];
                r_wcollect   <= 1'b1;
                r_wbusy      <= 1'b1;
                r_wbeat      <= 2'd1;
            end else if (r_wcollect && bfp_write) begin
                r_wbuf[{r_wbeat, 6'b0} +: 64] <= bfp_wdata;
                r_wbeat <= r_wbeat + 2'd1;
                if (r_wbeat == 2'd3) r_wcollect <= 1'b0;
            end
            if (r_state == S_MEM_WR && lmem_resp) r_wbusy <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_MEM_RD && lmem_resp) r_linebuf <= lmem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cur_addr   <= '0;
            r_beat       <= 2'd0;
            r_lmem_read  <= 1'b0;
            r_lmem_write <= 1'b0;
            r_rvalid     <= 1'b0;
            r_rdata      <= '0;
            r_raddr      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            if (w_take) r_cur_addr <= w_take_ent[26:0];
            r_beat       <= (r_state == S_BURST) ? w_beat_inc : 2'd0;
            r_lmem_read  <= w_lmem_read_nxt;
            r_lmem_write <= w_lmem_write_nxt;
            r_rvalid     <= w_rvalid_nxt;
            r_rdata      <= w_rdata_nxt;
            r_raddr      <= w_raddr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_take) w_state_nxt = w_take_ent[27] ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: if (lmem_resp) w_state_nxt = S_BURST;
            S_MEM_WR: if (lmem_resp) w_state_nxt = S_IDLE;
            S_BURST:  if (r_beat == 2'd3) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs are loaded from the next state; beat 0 comes straight off the memory bus.
    always_comb begin
        w_lmem_read_nxt  = (w_state_nxt == S_MEM_RD);
        w_lmem_write_nxt = (w_state_nxt == S_MEM_WR);
        w_rvalid_nxt     = (w_state_nxt == S_BURST);
        w_raddr_nxt      = w_rvalid_nxt ? {r_cur_addr, 5'b0} : 32'd0;
        w_rdata_nxt      = '0;
        if (r_state == S_MEM_RD && lmem_resp)
            w_rdata_nxt = lmem_rdata[63:0];
        else if (r_state == S_BURST && r_beat != 2'd3)
            w_rdata_nxt = r_linebuf[{w_beat_inc, 6'b0} +: 64];
    end

endmodule

// File: tb/tb_line_burst_responder.sv
// Directed bench for line_burst_responder: reset, single/queued reads, writes, ordering,
// reset during a burst and a stray memory response.
module tb_line_burst_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  bfp_addr;
    logic         bfp_read;
    logic         bfp_write;
    logic [63:0]  bfp_wdata;
    logic         bfp_ready;
    logic [31:0]  bfp_raddr;
    logic [63:0]  bfp_rdata;
    logic         bfp_rvalid;
    logic [31:0]  lmem_addr;
    logic         lmem_read;
    logic         lmem_write;
    logic [255:0] lmem_wdata;
    logic [255:0] lmem_rdata;
    logic         lmem_resp;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    line_burst_responder #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bfp_addr  (bfp_addr),
        .bfp_read  (bfp_read),
        .bfp_write (bfp_write),
        .bfp_wdata (bfp_wdata),
        .bfp_ready (bfp_ready),
        .bfp_raddr (bfp_raddr),
        .bfp_rdata (bfp_rdata),
        .bfp_rvalid(bfp_rvalid),
        .lmem_addr (lmem_addr),
        .lmem_read (lmem_read),
        .lmem_write(lmem_write),
        .lmem_wdata(lmem_wdata),
        .lmem_rdata(lmem_rdata),
        .lmem_resp (lmem_resp)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bfp_addr   = '0;
        bfp_read   = 1'b0;
        bfp_write  = 1'b0;
        bfp_wdata  = '0;
        lmem_rdata = '0;
        lmem_resp  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        total++; if (bfp_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", bfp_ready); end
        total++; if (bfp_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b want=0", bfp_rvalid); end
        total++; if (lmem_read !== 1'b0 || lmem_write !== 1'b0) begin bad++; $display("FAIL rst_lmem_op got rd=%b wr=%b want 0/0", lmem_read, lmem_write); end
        total++; if (lmem_addr !== 32'd0 || bfp_raddr !== 32'd0 || bfp_rdata !== 64'd0) begin bad++; $display("FAIL rst_data got laddr=%h raddr=%h rdata=%h want 0", lmem_addr, bfp_raddr, bfp_rdata); end
        total++; if (lmem_wdata !== 256'd0) begin bad++; $display("FAIL rst_wdata got=%h want 0", lmem_wdata); end
        rst = 1'b0;
        #1;
        total++; if (bfp_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b want=1", bfp_ready); end
        tick();
    endtask

    task automatic test_single_read;
        logic [255:0] line;
        line = {64'hD3D3_0303_D3D3_0303, 64'hD2D2_0202_D2D2_0202,
                64'hD1D1_0101_D1D1_0101, 64'hD0D0_0000_D0D0_0000};
        bfp_addr = 32'h0000_1234;
        bfp_read = 1'b1;
        total++; if (bfp_ready !== 1'b1) begin bad++; $display("FAIL sr_ready got=%b want=1", bfp_ready); end
        tick();
        bfp_read = 1'b0;
        bfp_addr = '0;
        for (int i = 1; i <= 5; i++) begin
            total++;
            if (lmem_read !== 1'b1 || lmem_write !== 1'b0 || lmem_addr !== 32'h0000_1220) begin
                bad++; $display("FAIL sr_lmem_read T+%0d got rd=%b wr=%b addr=%h want 1/0/00001220", i, lmem_read, lmem_write, lmem_addr);
            end
            total++; if (bfp_rvalid !== 1'b0) begin bad++; $display("FAIL sr_early_rvalid T+%0d got=%b want=0", i, bfp_rvalid); end
            if (i == 5) begin lmem_resp = 1'b1; lmem_rdata = line; end
            tick();
        end
        lmem_resp  = 1'b0;
        lmem_rdata = '0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (bfp_rvalid !== 1'b1 || bfp_rdata !== line[64*k +: 64] || bfp_raddr !== 32'h0000_1220) begin
                bad++; $display("FAIL sr_beat%0d got v=%b data=%h addr=%h want 1/%h/00001220", k, bfp_rvalid, bfp_rdata, bfp_raddr, line[64*k +: 64]);
            end
            total++; if (lmem_read !== 1'b0) begin bad++; $display("FAIL sr_read_during_burst beat%0d got=%b want=0", k, lmem_read); end
            tick();
        end
        total++; if (bfp_rvalid !== 1'b0) begin bad++; $display("FAIL sr_after_burst rvalid got=%b want=0", bfp_rvalid); end
    endtask

    task automatic test_queued_reads;
        logic [31:0]  addrs [5];
        logic [255:0] line;
        int beats;
        int grp;
        int rd_cnt;
        addrs[0] = 32'h0000_011F;
        addrs[1] = 32'h0000_0200;
        addrs[2] = 32'h0000_0333;
        addrs[3] = 32'h0000_0400;
        addrs[4] = 32'h0000_05E0;
        beats  = 0;
        grp    = 0;
        rd_cnt = 0;
        for (int cyc = 0; cyc < 300 && beats < 20; cyc++) begin
            if (cyc < 5) begin
                total++; if (bfp_ready !== 1'b1) begin bad++; $display("FAIL q_ready_open cyc%0d got=%b want=1", cyc, bfp_ready); end
                bfp_read = 1'b1;
                bfp_addr = addrs[cyc];
            end else begin
                bfp_read = 1'b0;
                bfp_addr = '0;
            end
            if (cyc == 5) begin
                total++; if (bfp_ready !== 1'b0) begin bad++; $display("FAIL q_ready_full got=%b want=0", bfp_ready); end
            end
            lmem_resp = 1'b0;
            if (lmem_read === 1'b1) begin
                rd_cnt++;
                if (rd_cnt == 1) begin
                    total++;
                    if (lmem_addr !== (addrs[grp] & 32'hFFFF_FFE0)) begin
                        bad++; $display("FAIL q_order grp%0d got=%h want=%h", grp, lmem_addr, addrs[grp] & 32'hFFFF_FFE0);
                    end
                end
                if (rd_cnt == 3) begin
                    for (int k = 0; k < 4; k++) line[64*k +: 64] = {32'(grp), 32'(k)};
                    lmem_resp  = 1'b1;
                    lmem_rdata = line;
                    rd_cnt     = 0;
                    grp++;
                end
            end
            if (bfp_rvalid === 1'b1) begin
                total++;
                if (bfp_raddr !== (addrs[beats/4] & 32'hFFFF_FFE0) || bfp_rdata !== {32'(beats/4), 32'(beats%4)}) begin
                    bad++; $display("FAIL q_beat%0d got addr=%h data=%h want %h/%h", beats, bfp_raddr, bfp_rdata,
                                    addrs[beats/4] & 32'hFFFF_FFE0, {32'(beats/4), 32'(beats%4)});
                end
                beats++;
            end
            tick();
        end
        idle_inputs();
        total++; if (beats != 20) begin bad++; $display("FAIL q_beat_count got=%0d want=20", beats); end
        tick();
        total++; if (bfp_rvalid !== 1'b0 || lmem_read !== 1'b0 || bfp_ready !== 1'b1) begin
            bad++; $display("FAIL q_drained got v=%b rd=%b rdy=%b want 0/0/1", bfp_rvalid, lmem_read, bfp_ready);
        end
    endtask

    task automatic test_write;
        logic [63:0]  beat [4];
        logic [255:0] exp_line;
        beat[0] = 64'h1111_1111_1111_1111;
        beat[1] = 64'h2222_2222_2222_2222;
        beat[2] = 64'h3333_3333_3333_3333;
        beat[3] = 64'h4444_4444_4444_4444;
        exp_line = {beat[3], beat[2], beat[1], beat[0]};
        total++; if (bfp_ready !== 1'b1) begin bad++; $display("FAIL wr_ready_start got=%b want=1", bfp_ready); end
        bfp_addr  = 32'h0000_0040;
        bfp_write = 1'b1;
        bfp_wdata = beat[0];
        tick();
        bfp_addr = '0;
        for (int b = 1; b < 4; b++) begin
            total++; if (bfp_ready !== 1'b0) begin bad++; $display("FAIL wr_ready_collect beat%0d got=%b want=0", b, bfp_ready); end
            bfp_wdata = beat[b];
            tick();
        end
        bfp_write = 1'b0;
        bfp_wdata = '0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (lmem_write !== 1'b1 || lmem_read !== 1'b0 || lmem_addr !== 32'h0000_0040 || lmem_wdata !== exp_line) begin
                bad++; $display("FAIL wr_lmem cyc%0d got wr=%b rd=%b addr=%h wdata=%h want 1/0/00000040/%h", i, lmem_write, lmem_read, lmem_addr, lmem_wdata, exp_line);
            end
            total++; if (bfp_ready !== 1'b0 || bfp_rvalid !== 1'b0) begin bad++; $display("FAIL wr_busy cyc%0d got rdy=%b v=%b want 0/0", i, bfp_ready, bfp_rvalid); end
            if (i == 2) lmem_resp = 1'b1;
            tick();
        end
        lmem_resp = 1'b0;
        total++; if (lmem_write !== 1'b0 || bfp_ready !== 1'b1 || bfp_rvalid !== 1'b0) begin
            bad++; $display("FAIL wr_done got wr=%b rdy=%b v=%b want 0/1/0", lmem_write, bfp_ready, bfp_rvalid);
        end
        tick();
        total++; if (bfp_rvalid !== 1'b0 || lmem_read !== 1'b0) begin bad++; $display("FAIL wr_no_resp got v=%b rd=%b want 0/0", bfp_rvalid, lmem_read); end
    endtask

    task automatic test_read_after_write;
        logic [255:0] line;
        line = {64'hAAAA_0003_0000_0080, 64'hAAAA_0002_0000_0080,
                64'hAAAA_0001_0000_0080, 64'hAAAA_0000_0000_0080};
        bfp_addr  = 32'h0000_0080;
        bfp_write = 1'b1;
        for (int b = 0; b < 4; b++) begin
            bfp_wdata = {32'hBEEF_0000, 32'(b)};
            tick();
        end
        idle_inputs();
        total++; if (lmem_write !== 1'b1 || lmem_read !== 1'b0 || lmem_addr !== 32'h0000_0080) begin
            bad++; $display("FAIL raw_write got wr=%b rd=%b addr=%h want 1/0/00000080", lmem_write, lmem_read, lmem_addr);
        end
        lmem_resp = 1'b1;
        tick();
        lmem_resp = 1'b0;
        total++; if (lmem_write !== 1'b0 || lmem_read !== 1'b0 || bfp_ready !== 1'b1) begin
            bad++; $display("FAIL raw_gap got wr=%b rd=%b rdy=%b want 0/0/1", lmem_write, lmem_read, bfp_ready);
        end
        bfp_addr = 32'h0000_0080;
        bfp_read = 1'b1;
        tick();
        idle_inputs();
        total++; if (lmem_read !== 1'b1 || lmem_write !== 1'b0 || lmem_addr !== 32'h0000_0080) begin
            bad++; $display("FAIL raw_read got rd=%b wr=%b addr=%h want 1/0/00000080", lmem_read, lmem_write, lmem_addr);
        end
        lmem_resp  = 1'b1;
        lmem_rdata = line;
        tick();
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (bfp_rvalid !== 1'b1 || bfp_rdata !== line[64*k +: 64] || bfp_raddr !== 32'h0000_0080) begin
                bad++; $display("FAIL raw_beat%0d got v=%b data=%h addr=%h want 1/%h/00000080", k, bfp_rvalid, bfp_rdata, bfp_raddr, line[64*k +: 64]);
            end
            tick();
        end
    endtask

    task automatic test_reset_burst;
        logic [255:0] line;
        line = {64'h6666_0003_0000_0600, 64'h6666_0002_0000_0600,
                64'h6666_0001_0000_0600, 64'h6666_0000_0000_0600};
        bfp_addr = 32'h0000_0600;
        bfp_read = 1'b1;
        tick();
        bfp_addr = 32'h0000_0700;
        total++; if (bfp_ready !== 1'b1) begin bad++; $display("FAIL rb_second_ready got=%b want=1", bfp_ready); end
        tick();
        idle_inputs();
        total++; if (lmem_read !== 1'b1 || lmem_addr !== 32'h0000_0600) begin bad++; $display("FAIL rb_read got rd=%b addr=%h want 1/00000600", lmem_read, lmem_addr); end
        lmem_resp  = 1'b1;
        lmem_rdata = line;
        tick();
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (bfp_rvalid !== 1'b1 || bfp_rdata !== line[64*k +: 64]) begin
                bad++; $display("FAIL rb_beat%0d got v=%b data=%h want 1/%h", k, bfp_rvalid, bfp_rdata, line[64*k +: 64]);
            end
            if (k == 1) rst = 1'b1;
            tick();
        end
        total++; if (bfp_rvalid !== 1'b0 || lmem_read !== 1'b0 || bfp_ready !== 1'b0) begin
            bad++; $display("FAIL rb_in_reset got v=%b rd=%b rdy=%b want 0/0/0", bfp_rvalid, lmem_read, bfp_ready);
        end
        rst = 1'b0;
        #1;
        total++; if (bfp_ready !== 1'b1) begin bad++; $display("FAIL rb_ready_after got=%b want=1", bfp_ready); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (bfp_rvalid !== 1'b0 || lmem_read !== 1'b0 || lmem_write !== 1'b0) begin
                bad++; $display("FAIL rb_quiet cyc%0d got v=%b rd=%b wr=%b want 0/0/0", i, bfp_rvalid, lmem_read, lmem_write);
            end
        end
    endtask

    task automatic test_spurious_resp;
        logic [255:0] line;
        line = {64'h7777_0003_0000_07C0, 64'h7777_0002_0000_07C0,
                64'h7777_0001_0000_07C0, 64'h7777_0000_0000_07C0};
        lmem_resp  = 1'b1;
        lmem_rdata = {4{64'hDEAD_BEEF_DEAD_BEEF}};
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            total++; if (bfp_rvalid !== 1'b0 || lmem_read !== 1'b0 || lmem_write !== 1'b0 || bfp_ready !== 1'b1) begin
                bad++; $display("FAIL sp_idle cyc%0d got v=%b rd=%b wr=%b rdy=%b want 0/0/0/1", i, bfp_rvalid, lmem_read, lmem_write, bfp_ready);
            end
            tick();
        end
        bfp_addr = 32'h0000_07C4;
        bfp_read = 1'b1;
        tick();
        idle_inputs();
        total++; if (lmem_read !== 1'b1 || lmem_addr !== 32'h0000_07C0) begin bad++; $display("FAIL sp_next_read got rd=%b addr=%h want 1/000007C0", lmem_read, lmem_addr); end
        lmem_resp  = 1'b1;
        lmem_rdata = line;
        tick();
        idle_inputs();
        total++; if (bfp_rvalid !== 1'b1 || bfp_rdata !== line[63:0] || bfp_raddr !== 32'h0000_07C0) begin
            bad++; $display("FAIL sp_beat0 got v=%b data=%h addr=%h want 1/%h/000007C0", bfp_rvalid, bfp_rdata, bfp_raddr, line[63:0]);
        end
        for (int i = 0; i < 4; i++) tick();
        total++; if (bfp_rvalid !== 1'b0) begin bad++; $display("FAIL sp_end got v=%b want 0", bfp_rvalid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_queued_reads();
        test_write();
        test_read_after_write();
        test_reset_burst();
        test_spurious_resp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_burst_responder.md
Name: line_burst_responder

Overview:
- Memory-side responder for the cache burst interface. It accepts line read and write requests from an icache or dcache miss FSM and queues them.
- Each request is serviced against a 256-bit line memory port.
- Read data returns as 4 consecutive 64-bit beats, each tagged with the aligned line address.
- The block sits between the cache arbiter and the line-wide DRAM model/controller.

Parameters:
- DEPTH, 4, request FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- bfp_addr  in  32  request byte address; bits [4:0] ignored
- bfp_read  in  1  line read request, qualified by bfp_ready
- bfp_write  in  1  line write request / write beat valid
- bfp_wdata  in  64  write beat data
- bfp_ready  out  1  request accept
- bfp_raddr  out  32  line address of current read beat, [4:0]=0
- bfp_rdata  out  64  read beat data
- bfp_rvalid  out  1  read beat valid
- lmem_addr  out  32  line address, [4:0]=0
- lmem_read  out  1  line read, held until lmem_resp
- lmem_write  out  1  line write, held until lmem_resp
- lmem_wdata  out  256  line write data
- lmem_rdata  in  256  line read data, valid with lmem_resp
- lmem_resp  in  1  line op complete, one-cycle pulse

Behaviour:
- Reset: rst is synchronous, active-high; clk is the clock.
  - During reset all outputs are 0, FIFO is empty and write buffer is free.
  - bfp_ready is 1 on the first cycle after rst deasserts.
- Request side:
  - bfp_ready = !fifo_full && !wcollect && !wbuf_busy. Computed from registered state only; no same-cycle pop bypass.
  - Read accepted when bfp_read && bfp_ready. {op=RD, addr&~32'h1f} is pushed that cycle.
  - bfp_read and bfp_write asserted together is illegal; the block treats it as a read.
  - Write accepted when bfp_write && bfp_ready (beat 0):
    - wbuf[63:0] = bfp_wdata; wcollect=1; wbuf_busy=1.
    - Beats 1..3 must arrive on the next 3 cycles with bfp_write=1. Beat k is stored to wbuf[64k+63:64k].
    - bfp_ready stays 0 during these beats.
    - {op=WR, addr} is pushed on the beat-3 cycle.
    - wbuf_busy clears on that write's lmem_resp.
- Service FSM states: IDLE, MEM_RD, MEM_WR, BURST.
  - IDLE: if FIFO is non-empty, pop the head and go to MEM_RD or MEM_WR per op. The popped entry is visible next cycle, so a read accepted at T into an empty FIFO asserts lmem_read at T+1.
  - MEM_RD: lmem_read=1 and lmem_addr=entry addr, held constant. On lmem_resp, capture lmem_rdata into the line buffer and go to BURST with beat=0.
  - MEM_WR: lmem_write=1 and lmem_wdata=wbuf, held. On lmem_resp, go to IDLE.
  - BURST: bfp_rvalid=1, bfp_raddr=line addr, bfp_rdata=linebuf[64*beat+63:64*beat], on 4 consecutive cycles with no backpressure.
    - With lmem_resp at R, beats occur at R+1..R+4.
    - At beat 3, go to IDLE.
- Outputs and ordering:
  - Outputs are registered. bfp_rvalid is never high outside BURST.
  - lmem_read and lmem_write are never high together.
  - Requests are serviced strictly in FIFO order.
  - Writes produce no bfp_rvalid response.
- FIFO: 2-bit-wider count, wrap-around pointers.
  - Push and pop in the same cycle leave the count unchanged.
  - Full blocks bfp_ready; empty holds the FSM in IDLE.
- Reset mid-operation: abandon burst, FIFO and write buffer; all outputs return to 0 the next cycle. No partial beats follow.
- A lmem_resp arriving outside MEM_RD/MEM_WR is ignored.

Test Plan:
- Single read:
  - Stimulus: bfp_read, addr 0x0000_1234 at T; lmem_resp at T+5 with rdata {D3,D2,D1,D0}.
  - Required: lmem_read T+1..T+5 with lmem_addr 0x1220; bfp_rvalid T+6..T+9 with D0..D3; raddr 0x1220 every beat.
- Queued reads:
  - Stimulus: 5 reads on back-to-back ready cycles with DEPTH=4; memory responds after 3 cycles.
  - Required: ready drops when full; reads issue in order; 20 beats total with the correct raddr per group.
- Write:
  - Stimulus: bfp_write addr 0x40 with beats 0x11..,0x22..,0x33..,0x44.. on T..T+3.
  - Required: ready=0 from T+1 until lmem_resp; lmem_wdata={0x44..,0x33..,0x22..,0x11..}; lmem_addr 0x40; no rvalid.
- Read after write ordering:
  - Stimulus: write to 0x80, then read 0x80.
  - Required: lmem_write completes before lmem_read asserts.
- Reset during BURST:
  - Stimulus: assert rst after beat 1.
  - Required: rvalid=0 next cycle; no further beats; FIFO empty; ready=1 after reset.
- Spurious lmem_resp:
  - Stimulus: lmem_resp pulse while IDLE with empty FIFO.
  - Required: no rvalid and no state change.
